// File: rtl/digit_scanner_if.sv
// Bus bundle for the seven-segment scan driver: display config/data in, scan position and segments out.
interface digit_scanner_if;
  logic [7:0]  i_config_digit;
  logic [31:0] i_data;
  logic [7:0]  i_dp;
  logic [2:0]  o_pos;
  logic [7:0]  o_seg;
  logic        o_blank;
  logic        o_frame;

  modport master (
    output i_config_digit, i_data, i_dp,
    input  o_pos, o_seg, o_blank, o_frame
  );

  modport slave (
    input  i_config_digit, i_data, i_dp,
    output o_pos, o_seg, o_blank, o_frame
  );
endinterface

// File: rtl/digit_scanner.sv
// Time-multiplexed 8-digit seven-segment scan driver with per-frame data snapshot.
// Define DIGIT_SCANNER_BLANK_EN to insert BLANK_CYCLES segments-off cycles between digit slots.
module digit_scanner #(
  parameter int CLK_DIV      = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  digit_scanner_if.slave  bus
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

`ifdef DIGIT_SCANNER_BLANK_EN
  localparam int BW = $clog2(BLANK_CYCLES + 1);
  localparam logic [BW-1:0] BCNT_LAST = BW'(BLANK_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHOW} state_t;
`endif

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    pos, pos_d;
  logic [7:0]    seg, seg_d;
  logic          blank, blank_d;
  logic          frame, frame_d;
  logic [31:0]   snap_data, snap_data_d;
  logic [7:0]    snap_dp, snap_dp_d;
  logic [3:0]    nxt;
`ifdef DIGIT_SCANNER_BLANK_EN
  logic [BW-1:0] bcnt, bcnt_d;
`endif

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  function automatic logic [7:0] seg_of(input logic [31:0] d, input logic [7:0] dp,
                                        input logic [2:0] p);
    return {dp[p], hex7(d[{p, 2'b00} +: 4])};
  endfunction

  // Returns {wrap, position}; wrap is set when no enabled index lies above cur.
  function automatic logic [3:0] next_pos(input logic [7:0] mask, input logic [2:0] cur);
    logic [2:0] lo, up;
    logic       found_up;
    lo = '0;
    up = '0;
    found_up = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) begin
        lo = 3'(i);
        if (3'(i) > cur) begin
          up = 3'(i);
          found_up = 1'b1;
        end
      end
    end
    return found_up ? {1'b0, up} : {1'b1, lo};
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      pos       <= '0;
      seg       <= '0;
      blank     <= 1'b1;
      frame     <= 1'b0;
      snap_data <= '0;
      snap_dp   <= '0;
`ifdef DIGIT_SCANNER_BLANK_EN
      bcnt      <= '0;
`endif
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      pos       <= pos_d;
      seg       <= seg_d;
      blank     <= blank_d;
      frame     <= frame_d;
      snap_data <= snap_data_d;
      snap_dp   <= snap_dp_d;
`ifdef DIGIT_SCANNER_BLANK_EN
      bcnt      <= bcnt_d;
`endif
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    pos_d       = pos;
    seg_d       = seg;
    blank_d     = blank;
    frame_d     = 1'b0;
    snap_data_d = snap_data;
    snap_dp_d   = snap_dp;
`ifdef DIGIT_SCANNER_BLANK_EN
    bcnt_d      = bcnt;
`endif
    // Searching above position 7 always wraps, so this also yields the lowest enabled index.
    nxt = next_pos(bus.i_config_digit, (state == IDLE) ? 3'd7 : pos);

    case (state)
      IDLE: begin
        seg_d   = '0;
        blank_d = 1'b1;
        if (bus.i_config_digit != 8'h00) begin
          snap_data_d = bus.i_data;
          snap_dp_d   = bus.i_dp;
          pos_d       = nxt[2:0];
          frame_d     = 1'b1;
          cnt_d       = '0;
`ifdef DIGIT_SCANNER_BLANK_EN
          state_d     = BLANK;
          bcnt_d      = '0;
`else
          state_d     = SHOW;
          seg_d       = seg_of(bus.i_data, bus.i_dp, nxt[2:0]);
          blank_d     = 1'b0;
`endif
        end
      end

      SHOW: begin
        if (cnt == CNT_LAST) begin
          cnt_d = '0;
          if (bus.i_config_digit == 8'h00) begin
            state_d = IDLE;
            seg_d   = '0;
            blank_d = 1'b1;
          end else begin
            pos_d = nxt[2:0];
            if (nxt[3]) begin
              snap_data_d = bus.i_data;
              snap_dp_d   = bus.i_dp;
              frame_d     = 1'b1;
            end
`ifdef DIGIT_SCANNER_BLANK_EN
            state_d = BLANK;
            bcnt_d  = '0;
            seg_d   = '0;
            blank_d = 1'b1;
`else
            seg_d   = seg_of(snap_data_d, snap_dp_d, nxt[2:0]);
`endif
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

`ifdef DIGIT_SCANNER_BLANK_EN
      BLANK: begin
        if (bcnt == BCNT_LAST) begin
          state_d = SHOW;
          cnt_d   = '0;
          seg_d   = seg_of(snap_data, snap_dp, pos);
          blank_d = 1'b0;
        end else begin
          bcnt_d = bcnt + 1'b1;
        end
      end
`endif

      default: begin
        state_d = IDLE;
        seg_d   = '0;
        blank_d = 1'b1;
      end
    endcase
  end

  assign bus.o_pos   = pos;
  assign bus.o_seg   = seg;
  assign bus.o_blank = blank;
  assign bus.o_frame = frame;

endmodule

// File: tb/tb_digit_scanner.sv
// Self-checking bench for digit_scanner: a slot-level reference model predicts every output cycle.
module tb_digit_scanner;

  localparam int CLK_DIV      = 4;
  localparam int BLANK_CYCLES = 2;
`ifdef DIGIT_SCANNER_BLANK_EN
  localparam int GAP = BLANK_CYCLES;
`else
  localparam int GAP = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  digit_scanner_if bus();

  digit_scanner #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK_CYCLES)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [2:0] pos;
    logic [7:0] seg;
    logic       blank;
    logic       frame;
  } exp_t;

  int n_checks = 0;
  int n_errors = 0;

  exp_t        q[$];
  int          m_pos;
  bit          m_idle;
  logic [31:0] m_data;
  logic [7:0]  m_dp;
  logic [7:0]  hex_tbl [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [7:0] expect_seg(int p);
    logic [3:0] nib;
    nib = m_data[4*p +: 4];
    return {m_dp[p], hex_tbl[nib][6:0]};
  endfunction

  // At a slot boundary, queue the expected outputs for the whole upcoming slot (or one idle cycle).
  function automatic void plan(logic [7:0] mask, logic [31:0] d, logic [7:0] dp);
    int   nxt;
    bit   wrap;
    exp_t e;
    if (mask == 8'h00) begin
      m_idle = 1'b1;
      e = '{pos: 3'(m_pos), seg: 8'h00, blank: 1'b1, frame: 1'b0};
      q.push_back(e);
      return;
    end
    nxt = -1;
    if (m_idle) begin
      for (int k = 0; k < 8; k++) if (nxt < 0 && mask[k]) nxt = k;
      wrap = 1'b1;
    end else begin
      for (int k = 1; k <= 8; k++) begin
        int idx;
        idx = (m_pos + k) % 8;
        if (nxt < 0 && mask[idx]) nxt = idx;
      end
      wrap = (nxt <= m_pos);
    end
    m_idle = 1'b0;
    m_pos  = nxt;
    if (wrap) begin
      m_data = d;
      m_dp   = dp;
    end
    for (int i = 0; i < GAP; i++) begin
      e = '{pos: 3'(m_pos), seg: 8'h00, blank: 1'b1, frame: wrap && (i == 0)};
      q.push_back(e);
    end
    for (int i = 0; i < CLK_DIV; i++) begin
      e = '{pos: 3'(m_pos), seg: expect_seg(m_pos), blank: 1'b0,
            frame: wrap && (i == 0) && (GAP == 0)};
      q.push_back(e);
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_pos  = 0;
      m_idle = 1'b1;
      m_data = '0;
      m_dp   = '0;
      q.push_back('{pos: 3'd0, seg: 8'h00, blank: 1'b1, frame: 1'b0});
    end else begin
      void'(q.pop_front());
      if (q.size() == 0) plan(bus.i_config_digit, bus.i_data, bus.i_dp);
    end
  end

  function automatic logic [12:0] observed();
    return {bus.o_pos, bus.o_seg, bus.o_blank, bus.o_frame};
  endfunction

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("cyc", {19'd0, observed()}, {19'd0, q[0]});
    end
  endtask

  initial begin
    bit seen;
    bus.i_config_digit = 8'hFF;
    bus.i_data         = 32'h76543210;
    bus.i_dp           = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_state", {19'd0, observed()}, {19'd0, 3'd0, 8'h00, 1'b1, 1'b0});
    rst_n = 1'b1;

    // full scan
    run(2 * 8 * (CLK_DIV + GAP) + 4);

    // sparse mask
    bus.i_config_digit = 8'b1010_0100;
    run(6 * (CLK_DIV + GAP) + 3);

    // single digit with decimal point
    bus.i_config_digit = 8'h10;
    bus.i_data         = 32'h0008_0000;
    bus.i_dp           = 8'h10;
    run(2 * (CLK_DIV + GAP) + 2);
    repeat (3 * (CLK_DIV + GAP)) begin
      run(1);
      chk("single_pos", {29'd0, bus.o_pos}, 32'd4);
      if (!bus.o_blank) chk("single_seg", {24'd0, bus.o_seg}, 32'hFF);
    end

    // snapshot: data changes mid-frame
    bus.i_config_digit = 8'hFF;
    bus.i_data         = 32'h0;
    bus.i_dp           = 8'h00;
    run(8 * (CLK_DIV + GAP) + 3 * (CLK_DIV + GAP) + 1);
    bus.i_data = 32'hFFFF_FFFF;
    run(2 * 8 * (CLK_DIV + GAP));

    // mask cleared mid-slot, later restored
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      run(1);
      if (!bus.o_blank) seen = 1'b1;
    end
    chk("wait_show1", {31'd0, seen}, 32'd1);
    bus.i_config_digit = 8'h00;
    run(CLK_DIV + GAP + 6);
    chk("idle_blank", {31'd0, bus.o_blank}, 32'd1);
    chk("idle_seg", {24'd0, bus.o_seg}, 32'd0);
    bus.i_config_digit = 8'h01;
    run(3 * (CLK_DIV + GAP));

    // asynchronous reset between edges during SHOW
    bus.i_config_digit = 8'hFF;
    bus.i_data         = 32'h89AB_CDEF;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      run(1);
      if (!bus.o_blank && bus.o_pos != 3'd0) seen = 1'b1;
    end
    chk("wait_show2", {31'd0, seen}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_pos", {29'd0, bus.o_pos}, 32'd0);
    chk("async_seg", {24'd0, bus.o_seg}, 32'd0);
    chk("async_blank", {31'd0, bus.o_blank}, 32'd1);
    run(2);
    rst_n = 1'b1;
    run(8 * (CLK_DIV + GAP) + 2);

    // randomized masks, data and mid-slot changes
    for (int it = 0; it < 40; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0)      bus.i_config_digit = 8'h00;
      else if (r < 8)  bus.i_config_digit = 8'($urandom);
      bus.i_data = $urandom;
      bus.i_dp   = 8'($urandom);
      run($urandom_range(3, 40));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
